// File: rtl/reg_scoreboard.sv
// Register-file hazard scoreboard for decode: per-register in-flight write
// counters, issue gating on source hazards and counter saturation, flush,
// sticky retire-underflow flag and a saturating stall-cycle counter.
module reg_scoreboard #(
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STALL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               issueValid,
  output logic               issueReady,
  input  logic [3:0]         srcA,
  input  logic [3:0]         srcB,
  input  logic [3:0]         dstE,
  input  logic [3:0]         dstM,
  input  logic               retireE,
  input  logic [3:0]         retireRegE,
  input  logic               retireM,
  input  logic [3:0]         retireRegM,
  input  logic               flush,
  output logic [14:0]        busyMask,
  output logic               stall,
  output logic [STALL_W-1:0] stallCycles,
  output logic               retireError
);

  localparam int unsigned NREG  = 15;
  // Two extra bits hold cnt + 2 without overflow when checking saturation.
  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] cnt_q      [NREG];
  logic [CNT_W-1:0] cnt_d      [NREG];
  logic [1:0]       issue_inc  [NREG];
  logic [1:0]       retire_dec [NREG];
  logic [SUM_W-1:0] sat_sum    [NREG];
  logic [SUM_W-1:0] net_sum    [NREG];
  logic             hazard;
  logic             sat;
  logic             issue_fire;
  logic             underflow;

  // Decode per-register increments/decrements and derive hazard and saturation.
  // ID 4'hF never matches any register index, so it is naturally a no-op.
  always_comb begin
    hazard = 1'b0;
    sat    = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      issue_inc[r]  = {1'b0, dstE == 4'(r)} + {1'b0, dstM == 4'(r)};
      retire_dec[r] = {1'b0, retireE && (retireRegE == 4'(r))}
                    + {1'b0, retireM && (retireRegM == 4'(r))};
      sat_sum[r]    = SUM_W'(cnt_q[r]) + SUM_W'(issue_inc[r]);
      if (cnt_q[r] != '0 && (srcA == 4'(r) || srcB == 4'(r))) begin
        hazard = 1'b1;
      end
      if (sat_sum[r] > CNT_MAX) begin
        sat = 1'b1;
      end
    end
  end

  // Issue gating uses current counter state only; same-cycle retires do not bypass.
  always_comb begin
    issueReady = !hazard && !sat && !flush;
    issue_fire = issueValid && issueReady;
    stall      = issueValid && !issueReady;
  end

  // Next counter values: net of issue and retire, clamped at zero on underflow.
  always_comb begin
    underflow = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      net_sum[r] = SUM_W'(cnt_q[r]) + (issue_fire ? SUM_W'(issue_inc[r]) : '0);
      if (flush) begin
        cnt_d[r] = '0;
      end else if (net_sum[r] < SUM_W'(retire_dec[r])) begin
        cnt_d[r]  = '0;
        underflow = 1'b1;
      end else begin
        // A fired issue never exceeds CNT_MAX, so truncation is lossless.
        cnt_d[r] = CNT_W'(net_sum[r] - SUM_W'(retire_dec[r]));
      end
    end
  end

  // Busy mask is a pure decode of registered counters.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      busyMask[r] = (cnt_q[r] != '0);
    end
  end

  // Counter, stall-cycle and sticky error state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      stallCycles <= '0;
      retireError <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      if (stall && (stallCycles != '1)) begin
        stallCycles <= stallCycles + STALL_W'(1);
      end
      if (underflow) begin
        retireError <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;

  logic        clock;
  logic        reset;
  logic        issueValid;
  logic        issueReady;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic        retireE, retireM;
  logic [3:0]  retireRegE, retireRegM;
  logic        flush;
  logic [14:0] busyMask;
  logic        stall;
  logic [15:0] stallCycles;
  logic        retireError;

  int errors = 0;
  int checks = 0;

  reg_scoreboard #(.CNT_W(2), .STALL_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .issueValid  (issueValid),
    .issueReady  (issueReady),
    .srcA        (srcA),
    .srcB        (srcB),
    .dstE        (dstE),
    .dstM        (dstM),
    .retireE     (retireE),
    .retireRegE  (retireRegE),
    .retireM     (retireM),
    .retireRegM  (retireRegM),
    .flush       (flush),
    .busyMask    (busyMask),
    .stall       (stall),
    .stallCycles (stallCycles),
    .retireError (retireError)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    issueValid = 1'b0;
    srcA = 4'hF; srcB = 4'hF; dstE = 4'hF; dstM = 4'hF;
    retireE = 1'b0; retireRegE = 4'hF;
    retireM = 1'b0; retireRegM = 4'hF;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #3;
    checks++; if (busyMask !== 15'h0) begin errors++; $display("FAIL rst_busy got %h want 0000", busyMask); end
    checks++; if (stallCycles !== 16'h0) begin errors++; $display("FAIL rst_stallcyc got %h want 0000", stallCycles); end
    checks++; if (retireError !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", retireError); end
    checks++; if (issueReady !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", issueReady); end
    @(negedge clock);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_hazard();
    issueValid = 1'b1; dstE = 4'd1;
    #1;
    checks++; if (issueReady !== 1'b1) begin errors++; $display("FAIL t1_ready0 got %b want 1", issueReady); end
    tick();
    dstE = 4'hF; srcA = 4'd1;
    #1;
    checks++; if (busyMask !== 15'h0002) begin errors++; $display("FAIL t1_busy got %h want 0002", busyMask); end
    checks++; if (issueReady !== 1'b0) begin errors++; $display("FAIL t1_haz_ready got %b want 0", issueReady); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL t1_stall got %b want 1", stall); end
    tick();
    retireE = 1'b1; retireRegE = 4'd1;
    #1;
    checks++; if (issueReady !== 1'b0) begin errors++; $display("FAIL t1_nobypass got %b want 0", issueReady); end
    tick();
    retireE = 1'b0; retireRegE = 4'hF;
    #1;
    checks++; if (issueReady !== 1'b1) begin errors++; $display("FAIL t1_ready1 got %b want 1", issueReady); end
    checks++; if (busyMask !== 15'h0) begin errors++; $display("FAIL t1_busy0 got %h want 0000", busyMask); end
    checks++; if (stallCycles !== 16'd2) begin errors++; $display("FAIL t1_stallcyc got %0d want 2", stallCycles); end
    tick();
    idle();
  endtask

  task automatic test_double_dest();
    issueValid = 1'b1; dstE = 4'd4; dstM = 4'd4;
    #1;
    checks++; if (issueReady !== 1'b1) begin errors++; $display("FAIL t2_ready got %b want 1", issueReady); end
    tick();
    issueValid = 1'b0;
    #1;
    checks++; if (busyMask !== 15'h0010) begin errors++; $display("FAIL t2_busy got %h want 0010", busyMask); end
    // cnt[4]=2, another +2 would reach 4 > 3
    checks++; if (issueReady !== 1'b0) begin errors++; $display("FAIL t2_sat got %b want 0", issueReady); end
    dstE = 4'hF; dstM = 4'hF;
    retireE = 1'b1; retireRegE = 4'd4; retireM = 1'b1; retireRegM = 4'd4;
    tick();
    idle();
    #1;
    checks++; if (busyMask !== 15'h0) begin errors++; $display("FAIL t2_busy0 got %h want 0000", busyMask); end
    checks++; if (retireError !== 1'b0) begin errors++; $display("FAIL t2_err got %b want 0", retireError); end
  endtask

  task automatic test_saturation();
    issueValid = 1'b1; dstE = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (issueReady !== 1'b1) begin errors++; $display("FAIL t3_fill%0d got %b want 1", i, issueReady); end
      tick();
    end
    #1;
    checks++; if (issueReady !== 1'b0) begin errors++; $display("FAIL t3_sat got %b want 0", issueReady); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL t3_stall got %b want 1", stall); end
    tick();
    retireE = 1'b1; retireRegE = 4'd2;
    #1;
    checks++; if (issueReady !== 1'b0) begin errors++; $display("FAIL t3_nobypass got %b want 0", issueReady); end
    tick();
    retireE = 1'b0; retireRegE = 4'hF;
    #1;
    checks++; if (issueReady !== 1'b1) begin errors++; $display("FAIL t3_reissue got %b want 1", issueReady); end
    tick();
    issueValid = 1'b0;
    #1;
    checks++; if (issueReady !== 1'b0) begin errors++; $display("FAIL t3_full_again got %b want 0", issueReady); end
    dstE = 4'hF; retireE = 1'b1; retireRegE = 4'd2;
    tick();
    tick();
    checks++; if (busyMask !== 15'h0004) begin errors++; $display("FAIL t3_busy1 got %h want 0004", busyMask); end
    tick();
    idle();
    #1;
    checks++; if (busyMask !== 15'h0) begin errors++; $display("FAIL t3_busy0 got %h want 0000", busyMask); end
    checks++; if (retireError !== 1'b0) begin errors++; $display("FAIL t3_err got %b want 0", retireError); end
  endtask

  task automatic test_issue_retire_same();
    issueValid = 1'b1; dstE = 4'd3;
    tick();
    retireE = 1'b1; retireRegE = 4'd3;
    #1;
    checks++; if (issueReady !== 1'b1) begin errors++; $display("FAIL t4_ready got %b want 1", issueReady); end
    tick();
    idle();
    #1;
    checks++; if (busyMask !== 15'h0008) begin errors++; $display("FAIL t4_busy got %h want 0008", busyMask); end
    srcB = 4'd3;
    #1;
    checks++; if (issueReady !== 1'b0) begin errors++; $display("FAIL t4_srcb got %b want 0", issueReady); end
    srcB = 4'hF; retireE = 1'b1; retireRegE = 4'd3;
    tick();
    idle();
    #1;
    checks++; if (busyMask !== 15'h0) begin errors++; $display("FAIL t4_busy0 got %h want 0000", busyMask); end
    checks++; if (retireError !== 1'b0) begin errors++; $display("FAIL t4_err got %b want 0", retireError); end
  endtask

  task automatic test_flush();
    issueValid = 1'b1; dstE = 4'd4; dstM = 4'd5;
    tick();
    dstE = 4'd6; dstM = 4'd7;
    tick();
    idle();
    #1;
    checks++; if (busyMask !== 15'h00F0) begin errors++; $display("FAIL t5_busy got %h want 00f0", busyMask); end
    flush = 1'b1; issueValid = 1'b1; dstE = 4'd5;
    retireE = 1'b1; retireRegE = 4'd8;
    #1;
    checks++; if (issueReady !== 1'b0) begin errors++; $display("FAIL t5_ready got %b want 0", issueReady); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL t5_stall got %b want 1", stall); end
    tick();
    idle();
    #1;
    checks++; if (busyMask !== 15'h0) begin errors++; $display("FAIL t5_busy0 got %h want 0000", busyMask); end
    checks++; if (retireError !== 1'b0) begin errors++; $display("FAIL t5_err0 got %b want 0", retireError); end
    checks++; if (stallCycles !== 16'd5) begin errors++; $display("FAIL t5_stallcyc got %0d want 5", stallCycles); end
    retireE = 1'b1; retireRegE = 4'd6;
    tick();
    idle();
    #1;
    checks++; if (retireError !== 1'b1) begin errors++; $display("FAIL t5_err1 got %b want 1", retireError); end
    flush = 1'b1;
    tick();
    idle();
    #1;
    checks++; if (retireError !== 1'b1) begin errors++; $display("FAIL t5_sticky got %b want 1", retireError); end
  endtask

  task automatic test_async_reset_and_stall_sat();
    test_reset();
    retireE = 1'b1; retireRegE = 4'd9;
    tick();
    idle();
    #1;
    checks++; if (retireError !== 1'b1) begin errors++; $display("FAIL t6_err got %b want 1", retireError); end
    issueValid = 1'b1; dstE = 4'd1;
    tick();
    dstE = 4'hF; srcA = 4'd1;
    repeat (7) tick();
    checks++; if (stallCycles !== 16'd7) begin errors++; $display("FAIL t6_stall7 got %0d want 7", stallCycles); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL t6_stall got %b want 1", stall); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (busyMask !== 15'h0) begin errors++; $display("FAIL t6_busy got %h want 0000", busyMask); end
    checks++; if (stallCycles !== 16'h0) begin errors++; $display("FAIL t6_stallcyc got %h want 0000", stallCycles); end
    checks++; if (retireError !== 1'b0) begin errors++; $display("FAIL t6_err0 got %b want 0", retireError); end
    checks++; if (issueReady !== 1'b1) begin errors++; $display("FAIL t6_ready got %b want 1", issueReady); end
    @(negedge clock);
    reset = 1'b0;
    tick();
    srcA = 4'hF; dstE = 4'd1;
    tick();
    dstE = 4'hF; srcA = 4'd1;
    repeat (65534) tick();
    checks++; if (stallCycles !== 16'hFFFE) begin errors++; $display("FAIL t6_near_sat got %h want fffe", stallCycles); end
    repeat (3) tick();
    checks++; if (stallCycles !== 16'hFFFF) begin errors++; $display("FAIL t6_sat got %h want ffff", stallCycles); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_hazard();
    test_double_dest();
    test_saturation();
    test_issue_retire_same();
    test_flush();
    test_async_reset_and_stall_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
